// File: rtl/alu_extend_pipe.sv
// Pipelined sign/zero-extend unit: result and flags are computed on accept and
// carried through PIPE_DEPTH valid/ready stages to writeback.
module alu_extend_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [3:0]            opcode,
   input  logic [1:0]            ext_size,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [3:0]            result_flags
);

   localparam logic [3:0] OP_SEX = 4'hA;
   localparam logic [3:0] OP_ZEX = 4'hB;

   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic [DATA_WIDTH-1:0] res_q [PIPE_DEPTH];
   logic [DATA_WIDTH-1:0] res_d [PIPE_DEPTH];
   logic [3:0]            flg_q [PIPE_DEPTH];
   logic [3:0]            flg_d [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] ld;

   logic [DATA_WIDTH-1:0] lo_mask, ext_res;
   logic [3:0]            ext_flg;
   logic                  ext_ovf, sign_bit, busy;
   int                    src_w;

   always_comb begin
      case (ext_size)
         2'b00:   src_w = 8;
         2'b01:   src_w = 16;
         2'b10:   src_w = 32;
         default: src_w = DATA_WIDTH;
      endcase
      lo_mask  = ~({DATA_WIDTH{1'b1}} << src_w);
      // top set bit of the mask picks the source sign bit without a variable index
      sign_bit = |(data_a & (lo_mask ^ (lo_mask >> 1)));
      ext_ovf  = 1'b0;
      ext_res  = data_a;
      if (opcode != OP_SEX && opcode != OP_ZEX) begin
         ext_res = '0;
         ext_ovf = 1'b1;
      end else if (ext_size == 2'b11 || src_w >= DATA_WIDTH) begin
         ext_res = data_a;
         ext_ovf = (src_w > DATA_WIDTH);
      end else if (opcode == OP_SEX) begin
         ext_res = (data_a & lo_mask) | (sign_bit ? ~lo_mask : '0);
      end else begin
         ext_res = data_a & lo_mask;
      end
      ext_flg = {1'b0, ext_ovf, ext_res[DATA_WIDTH-1], (ext_res == '0)};
   end

   // Stage k can load when result_ready is high or any stage from k onward is empty.
   always_comb begin
      ld   = '0;
      busy = 1'b0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         busy = 1'b1;
         for (int j = k; j < PIPE_DEPTH; j++) busy = busy & vld_q[j];
         ld[k] = result_ready || !busy;
      end
   end

   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      flg_d = flg_q;
      if (ld[0]) begin
         vld_d[0] = data_valid;
         if (data_valid) begin
            res_d[0] = ext_res;
            flg_d[0] = ext_flg;
         end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         if (ld[k]) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               res_d[k] = res_q[k-1];
               flg_d[k] = flg_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            res_q[k] <= '0;
            flg_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            res_q[k] <= res_d[k];
            flg_q[k] <= flg_d[k];
         end
      end
   end

   assign data_ready   = ld[0];
   assign result       = res_q[PIPE_DEPTH-1];
   assign result_flags = flg_q[PIPE_DEPTH-1];
   assign result_valid = vld_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_alu_extend_pipe.sv
// Bench for alu_extend_pipe: a 32-bit/depth-2 and a 16-bit/depth-3 instance,
// each checked every cycle against an in-order expected-result queue.
module tb_alu_extend_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        dv_a, dr_a, rv_a, rr_a;
   logic [3:0]  op_a, fl_a;
   logic [1:0]  sz_a;
   logic [31:0] da_a, res_a;

   logic        dv_b, dr_b, rv_b, rr_b;
   logic [3:0]  op_b, fl_b;
   logic [1:0]  sz_b;
   logic [15:0] da_b, res_b;

   int tests = 0;
   int fails = 0;

   alu_extend_pipe #(.DATA_WIDTH(32), .PIPE_DEPTH(2)) dut32 (
      .clk(clk), .reset(reset), .data_valid(dv_a), .data_ready(dr_a),
      .opcode(op_a), .ext_size(sz_a), .data_a(da_a), .result(res_a),
      .result_valid(rv_a), .result_ready(rr_a), .result_flags(fl_a));

   alu_extend_pipe #(.DATA_WIDTH(16), .PIPE_DEPTH(3)) dut16 (
      .clk(clk), .reset(reset), .data_valid(dv_b), .data_ready(dr_b),
      .opcode(op_b), .ext_size(sz_b), .data_a(da_b), .result(res_b),
      .result_valid(rv_b), .result_ready(rr_b), .result_flags(fl_b));

   // Extension as arithmetic: keep the low S bits, subtract 2^S when signed and negative.
   function automatic logic [35:0] model(int dw, logic [3:0] op, logic [1:0] sz, logic [31:0] a);
      longint s, v, m;
      logic [31:0] r;
      logic ov;
      s  = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : (sz == 2'd2) ? 32 : longint'(dw);
      m  = (longint'(1) << dw) - 1;
      ov = 1'b0;
      if (op != 4'hA && op != 4'hB) begin
         r  = 32'h0;
         ov = 1'b1;
      end else if (sz == 2'd3 || s >= longint'(dw)) begin
         r  = a & m[31:0];
         ov = (s > longint'(dw));
      end else begin
         v = longint'(a) % (longint'(1) << s);
         if (op == 4'hA && v >= (longint'(1) << (s - 1))) v = v - (longint'(1) << s);
         r = 32'(v & m);
      end
      return {1'b0, ov, r[dw-1], (r == 32'h0), r};
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Per-cycle scoreboards
   logic [35:0] q32[$];
   logic [35:0] q16[$];
   logic        pst32 = 1'b0, pst16 = 1'b0;
   logic [35:0] prev32, prev16;

   always @(negedge clk) begin
      if (reset) begin
         q32.delete();
         pst32 = 1'b0;
      end else begin
         if (pst32) chk("hold32", {rv_a, fl_a, res_a}, {1'b1, prev32});
         if (rv_a) begin
            if (q32.size() == 0) begin
               tests++; fails++;
               $display("FAIL spurious32: result %h with no op outstanding", res_a);
            end else chk("model32", {fl_a, res_a}, q32[0]);
            if (rr_a && q32.size() != 0) void'(q32.pop_front());
         end
         if (dv_a && dr_a) q32.push_back(model(32, op_a, sz_a, da_a));
         pst32  = rv_a && !rr_a;
         prev32 = {fl_a, res_a};
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q16.delete();
         pst16 = 1'b0;
      end else begin
         if (pst16) chk("hold16", {rv_b, fl_b, 16'h0, res_b}, {1'b1, prev16});
         if (rv_b) begin
            if (q16.size() == 0) begin
               tests++; fails++;
               $display("FAIL spurious16: result %h with no op outstanding", res_b);
            end else chk("model16", {fl_b, 16'h0, res_b}, q16[0]);
            if (rr_b && q16.size() != 0) void'(q16.pop_front());
         end
         if (dv_b && dr_b) q16.push_back(model(16, op_b, sz_b, {16'h0, da_b}));
         pst16  = rv_b && !rr_b;
         prev16 = {fl_b, 16'h0, res_b};
      end
   end

   task automatic put32(logic [3:0] op, logic [1:0] sz, logic [31:0] a);
      bit ok = 0;
      int n = 0;
      op_a = op; sz_a = sz; da_a = a; dv_a = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clk); ok = dr_a;
         @(posedge clk); #1; n++;
      end
      if (!ok) begin tests++; fails++; $display("FAIL put32: op not accepted in 50 cycles"); end
   endtask

   task automatic put16(logic [3:0] op, logic [1:0] sz, logic [15:0] a);
      bit ok = 0;
      int n = 0;
      op_b = op; sz_b = sz; da_b = a; dv_b = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clk); ok = dr_b;
         @(posedge clk); #1; n++;
      end
      if (!ok) begin tests++; fails++; $display("FAIL put16: op not accepted in 50 cycles"); end
   endtask

   // Single op into an idle pipe: valid must appear exactly PIPE_DEPTH cycles after presentation.
   task automatic lat32(string name, logic [3:0] op, logic [1:0] sz, logic [31:0] a,
                        logic [31:0] er, logic [3:0] ef);
      @(posedge clk); #1;
      put32(op, sz, a);
      dv_a = 1'b0;
      @(negedge clk); chk({name, "_early"}, {63'h0, rv_a}, 64'h0);
      @(negedge clk); chk(name, {rv_a, fl_a, res_a}, {1'b1, ef, er});
   endtask

   task automatic lat16(string name, logic [3:0] op, logic [1:0] sz, logic [15:0] a,
                        logic [15:0] er, logic [3:0] ef);
      @(posedge clk); #1;
      put16(op, sz, a);
      dv_b = 1'b0;
      repeat (2) begin @(negedge clk); chk({name, "_early"}, {63'h0, rv_b}, 64'h0); end
      @(negedge clk); chk(name, {rv_b, fl_b, res_b}, {1'b1, ef, er});
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin : main
      bit saw_drop;
      int got, cyc;
      reset = 1'b1;
      dv_a = 0; rr_a = 1; op_a = 0; sz_a = 0; da_a = 0;
      dv_b = 0; rr_b = 1; op_b = 0; sz_b = 0; da_b = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst32", {rv_a, fl_a, res_a, dr_a}, {1'b0, 4'h0, 32'h0, 1'b1});
      chk("rst16", {rv_b, fl_b, res_b, dr_b}, {1'b0, 4'h0, 16'h0, 1'b1});

      chk("pin_sex8",  model(32, 4'hA, 2'd0, 32'h1234_5680), {4'b0010, 32'hFFFF_FF80});
      chk("pin_ill16", model(16, 4'h3, 2'd1, 32'h0000_FFFF), {4'b0101, 32'h0});

      lat32("sex8",  4'hA, 2'd0, 32'h1234_5680, 32'hFFFF_FF80, 4'b0010);
      lat32("zex16", 4'hB, 2'd1, 32'hDEAD_8001, 32'h0000_8001, 4'b0000);
      lat32("zex8z", 4'hB, 2'd0, 32'h0000_0100, 32'h0000_0000, 4'b0001);
      lat32("illeg", 4'h3, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0101);
      lat32("sex32", 4'hA, 2'd2, 32'h8000_0000, 32'h8000_0000, 4'b0010);

      // Six back-to-back ops; output stalled for cycles 2..5 of the stream
      @(posedge clk); #1;
      fork
         begin
            put32(4'hA, 2'd2, 32'h8000_0000);
            put32(4'hB, 2'd3, 32'hCAFE_F00D);
            put32(4'hA, 2'd1, 32'h0000_FFFF);
            put32(4'hB, 2'd0, 32'h1234_56FE);
            put32(4'h5, 2'd1, 32'h0000_0001);
            put32(4'hA, 2'd0, 32'hFFFF_FF7F);
            dv_a = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 rr_a = 1'b0;
            saw_drop = 0;
            repeat (4) begin @(negedge clk); if (!dr_a) saw_drop = 1; end
            @(posedge clk); #1 rr_a = 1'b1;
            got = 0; cyc = 0;
            while (got < 6 && cyc < 20) begin
               @(negedge clk); cyc++;
               if (rv_a && rr_a) got++;
            end
         end
      join
      chk("stall_ready_drop", {63'h0, saw_drop}, 64'h1);
      chk("stream_retired", 64'(got), 64'd6);
      chk("stream_no_bubble", 64'(cyc), 64'd6);

      // Reset with two ops in flight and the output stalled
      @(posedge clk); #1 rr_a = 1'b0;
      put32(4'hA, 2'd0, 32'h0000_0080);
      put32(4'hB, 2'd1, 32'h0001_0002);
      reset = 1'b1; op_a = 4'hA; sz_a = 2'd0; da_a = 32'h0000_00FF; dv_a = 1'b1;
      @(posedge clk); #1 reset = 1'b0; dv_a = 1'b0; rr_a = 1'b1;
      @(negedge clk);
      chk("midrst", {rv_a, fl_a, res_a, dr_a}, {1'b0, 4'h0, 32'h0, 1'b1});
      lat32("post_rst", 4'hA, 2'd1, 32'h0000_7FFF, 32'h0000_7FFF, 4'b0000);

      lat16("w16_sex32", 4'hA, 2'd2, 16'h8001, 16'h8001, 4'b0110);
      lat16("w16_full",  4'hA, 2'd3, 16'h8001, 16'h8001, 4'b0010);
      lat16("w16_sex8",  4'hA, 2'd0, 16'h00FF, 16'hFFFF, 4'b0010);
      lat16("w16_zex16", 4'hB, 2'd1, 16'h0000, 16'h0000, 4'b0001);

      repeat (5) @(negedge clk);
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("drain16", 64'(q16.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
